// File: rtl/load_m_pkg.sv
// load_m_pkg: state encoding, default widths and helpers for load_m_strided.
package load_m_pkg;

    localparam int DEF_TILE_WIDTH = 256;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 24;
    localparam int DEF_DIM_WIDTH  = 10;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

    // Integer ceiling division; den is always a nonzero elaboration constant here.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/load_m_addr_gen.sv
// load_m_addr_gen: walks rows/tiles/lanes of a latched command and drives the
// memory read port. Padding lanes (column >= cols) suppress the read.
module load_m_addr_gen
    import load_m_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DIM_WIDTH  = DEF_DIM_WIDTH,
    parameter int ELEMS      = DEF_TILE_WIDTH / DEF_DATA_WIDTH,
    localparam int LW        = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  slot,
    input  logic                  next_tile,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    input  logic [DIM_WIDTH-1:0]  stride,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LW-1:0]         lane,
    output logic                  pad,
    output logic                  lane_end,
    output logic                  last_col,
    output logic                  last
);

    // Column counter must cover cols rounded up to a whole tile.
    localparam int CW = DIM_WIDTH + LW + 1;
    localparam int TW = DIM_WIDTH + 1;

    logic [DIM_WIDTH-1:0]  rows_q, cols_q, pitch_q, row_q;
    logic [TW-1:0]         tile_q, tiles_per_row;
    logic [CW-1:0]         col_base, col;
    logic [ADDR_WIDTH-1:0] base;

    assign tiles_per_row = TW'(ceil_div(32'(cols_q), 32'(ELEMS)));
    assign col           = col_base + CW'(lane);
    assign pad           = col >= CW'(cols_q);
    assign mem_re        = slot && !pad;
    assign mem_addr      = mem_re ? base + ADDR_WIDTH'(col) : '0;
    assign lane_end      = lane == LW'(ELEMS - 1);
    assign last_col      = tile_q == tiles_per_row - TW'(1);
    assign last          = last_col && (row_q == rows_q - DIM_WIDTH'(1));

    // Latch the command, sweep lanes during fetch, step tile/row on each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q   <= '0;
            cols_q   <= '0;
            pitch_q  <= '0;
            row_q    <= '0;
            tile_q   <= '0;
            col_base <= '0;
            base     <= '0;
            lane     <= '0;
        end else if (load) begin
            rows_q   <= rows;
            cols_q   <= cols;
            pitch_q  <= (stride == '0) ? cols : stride;
            row_q    <= '0;
            tile_q   <= '0;
            col_base <= '0;
            base     <= dram_addr;
            lane     <= '0;
        end else begin
            if (slot)
                lane <= lane_end ? '0 : lane + LW'(1);
            if (next_tile) begin
                if (last_col) begin
                    row_q    <= row_q + DIM_WIDTH'(1);
                    base     <= base + ADDR_WIDTH'(pitch_q);
                    tile_q   <= '0;
                    col_base <= '0;
                end else begin
                    tile_q   <= tile_q + TW'(1);
                    col_base <= col_base + CW'(ELEMS);
                end
            end
        end
    end

endmodule

// File: rtl/load_m_strided.sv
// load_m_strided: strided matrix loader emitting zero-padded row tiles over
// valid/ready. Define LOAD_M_DIM_CHECK_EN to reject zero dimensions and
// overlapping strides with an err pulse instead of honouring them.
module load_m_strided
    import load_m_pkg::*;
#(
    parameter int TILE_WIDTH = DEF_TILE_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DIM_WIDTH  = DEF_DIM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    input  logic [DIM_WIDTH-1:0]  stride,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [TILE_WIDTH-1:0] tile_data,
    output logic                  tile_valid,
    input  logic                  tile_ready,
    output logic                  tile_last_col,
    output logic                  tile_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int ELEMS = TILE_WIDTH / DATA_WIDTH;
    localparam int LW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    state_t                              state, state_n;
    logic                                dim_bad, load, slot, next_tile;
    logic [LW-1:0]                       lane, wr_lane;
    logic                                pad, lane_end, ag_last_col, ag_last;
    logic                                wr_en, wr_pad, last_col_q, last_q;
    logic [ELEMS-1:0][DATA_WIDTH-1:0]    tile_q;

    assign load          = (state == IDLE) && start;
    assign slot          = state == FETCH;
    assign next_tile     = (state == EMIT) && tile_ready;
    assign tile_valid    = state == EMIT;
    assign busy          = (state == FETCH) || (state == WAIT) || (state == EMIT);
    assign done          = state == DONE;
    assign tile_data     = tile_q;
    assign tile_last_col = tile_valid && last_col_q;
    assign tile_last     = tile_valid && last_q;

    // Commands that produce no reads go straight to DONE.
    always_comb begin
        dim_bad = (rows == '0) || (cols == '0);
`ifdef LOAD_M_DIM_CHECK_EN
        if ((stride != '0) && (stride < cols))
            dim_bad = 1'b1;
`endif
    end

    load_m_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH),
        .ELEMS      (ELEMS)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .slot      (slot),
        .next_tile (next_tile),
        .dram_addr (dram_addr),
        .rows      (rows),
        .cols      (cols),
        .stride    (stride),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .lane      (lane),
        .pad       (pad),
        .lane_end  (lane_end),
        .last_col  (ag_last_col),
        .last      (ag_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state: fetch a tile, let the final read land, hold it until accepted.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start) state_n = dim_bad ? DONE : FETCH;
            FETCH: if (lane_end) state_n = WAIT;
            WAIT:  state_n = EMIT;
            EMIT:  if (tile_ready) state_n = ag_last ? DONE : FETCH;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Delay lane/pad by one cycle to line up with the read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_pad  <= 1'b0;
            wr_lane <= '0;
        end else begin
            wr_en   <= slot;
            wr_pad  <= pad;
            wr_lane <= lane;
        end
    end

    // Tile register: each lane gets read data or zero padding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tile_q <= '0;
        else if (wr_en)
            tile_q[wr_lane] <= wr_pad ? '0 : mem_rdata;
    end

    // Capture the row/command end flags alongside the completed tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_col_q <= 1'b0;
            last_q     <= 1'b0;
        end else if (state == WAIT) begin
            last_col_q <= ag_last_col;
            last_q     <= ag_last;
        end
    end

`ifdef LOAD_M_DIM_CHECK_EN
    // One-cycle error pulse for a rejected command, coincident with DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= load && dim_bad;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_load_m_strided.sv
// Bench for load_m_strided: directed commands, reference tile/address model,
// per-cycle compare of reads and tiles, timing and literal pin checks.
module tb_load_m_strided;

    localparam int TW = 256, DW = 8, AW = 24, DIMW = 10;
    localparam int ELEMS = TW / DW;

    typedef struct packed {
        logic [TW-1:0] data;
        logic          lc;
        logic          l;
    } tile_t;

    logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AW-1:0]   dram_addr, mem_addr;
    logic [DIMW-1:0] rows, cols, stride;
    logic            mem_re, tile_valid, tile_ready, tile_last_col, tile_last;
    logic            busy, done, err;
    logic [DW-1:0]   mem_rdata = '0;
    logic [TW-1:0]   tile_data;

    tile_t         exp_tile[$], got_tiles[$];
    logic [AW-1:0] exp_addr[$], rd_log[$];
    int vectors = 0, miscompares = 0, n_reads = 0, exp_reads = 0;

    always #5 clk = ~clk;

    load_m_strided dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dram_addr(dram_addr),
        .rows(rows), .cols(cols), .stride(stride), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .tile_data(tile_data),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_last_col(tile_last_col), .tile_last(tile_last),
        .busy(busy), .done(done), .err(err)
    );

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    // Memory: data one cycle after the read; junk otherwise.
    always @(posedge clk) mem_rdata <= mem_re ? memf(mem_addr) : 8'hEE;

    task automatic check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: the full read sequence and tile list of a command.
    task automatic build_model(input logic [AW-1:0] a, input int r, input int c, input int s,
                               output bit bad);
        int p, tpr, col;
        tile_t t;
        bad = (r == 0) || (c == 0);
`ifdef LOAD_M_DIM_CHECK_EN
        if (s != 0 && s < c) bad = 1'b1;
`endif
        exp_addr.delete();
        exp_tile.delete();
        exp_reads = 0;
        if (bad) return;
        p   = (s == 0) ? c : s;
        tpr = (c + ELEMS - 1) / ELEMS;
        for (int ri = 0; ri < r; ri++) begin
            for (int ci = 0; ci < c; ci++)
                exp_addr.push_back(AW'(int'(a) + ri * p + ci));
            for (int ti = 0; ti < tpr; ti++) begin
                t.data = '0;
                for (int e = 0; e < ELEMS; e++) begin
                    col = ti * ELEMS + e;
                    if (col < c) t.data[e*DW +: DW] = memf(AW'(int'(a) + ri * p + col));
                end
                t.lc = (ti == tpr - 1);
                t.l  = t.lc && (ri == r - 1);
                exp_tile.push_back(t);
            end
        end
        exp_reads = r * c;
    endtask

    // Compare process: every read and every presented tile against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_re) begin
                rd_log.push_back(mem_addr);
                n_reads++;
                if (exp_addr.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rd_extra got=%0h expected=no read", mem_addr);
                end else
                    check("rd_addr", mem_addr, exp_addr.pop_front());
            end
            if (tile_valid) begin
                if (exp_tile.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL tile_extra got=%0h expected=no tile", tile_data);
                end else begin
                    check("tile_data", tile_data, exp_tile[0].data);
                    check("tile_last_col", tile_last_col, exp_tile[0].lc);
                    check("tile_last", tile_last, exp_tile[0].l);
                    if (tile_ready) begin
                        got_tiles.push_back('{tile_data, tile_last_col, tile_last});
                        void'(exp_tile.pop_front());
                    end
                end
            end
        end
    end

    task automatic check_reset_outs(input string name);
        check({name, "_data"}, tile_data, '0);
        check({name, "_ctl"}, {tile_valid, tile_last_col, tile_last, mem_re, busy, done, err, mem_addr}, '0);
    endtask

    // Issue one command and drive ready; abort_hs > 0 resets after that many handshakes.
    task automatic run_cmd(input logic [AW-1:0] a, input int r, input int c, input int s,
                           input bit stall, input int abort_hs);
        int cyc, first_v, prev_hs, n_hs, done_cyc, stall_left, abort_at;
        bit bad, err_cmd;
        build_model(a, r, c, s, bad);
        err_cmd = 1'b0;
`ifdef LOAD_M_DIM_CHECK_EN
        err_cmd = bad;
`endif
        rd_log.delete();
        got_tiles.delete();
        n_reads = 0;
        @(posedge clk); #1;
        dram_addr = a; rows = DIMW'(r); cols = DIMW'(c); stride = DIMW'(s); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; first_v = -1; prev_hs = -1; n_hs = 0; done_cyc = -1; abort_at = -1;
        stall_left = stall ? int'($urandom_range(0, 10)) : 0;
        while (done_cyc < 0 && cyc < 5000) begin
            if (cyc == 3 && !bad) begin
                start = 1'b1; dram_addr = 24'h0ABCDE; rows = 7; cols = 3;
            end else
                start = 1'b0;
            if (!stall) tile_ready = 1'b1;
            else if (tile_valid) begin
                if (stall_left > 0) begin tile_ready = 1'b0; stall_left--; end
                else tile_ready = 1'b1;
            end else
                tile_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (tile_valid && first_v < 0) first_v = cyc;
            if (tile_valid && tile_ready) begin
                if (!stall && prev_hs >= 0) check("tile_spacing", cyc - prev_hs, ELEMS + 2);
                prev_hs = cyc;
                n_hs++;
                if (n_hs == abort_hs) abort_at = cyc + 4;
                stall_left = stall ? int'($urandom_range(0, 10)) : 0;
            end
            check("err", err, err_cmd && cyc == 1);
            if (done) done_cyc = cyc;
            check("busy", busy, !bad && !done);
            if (cyc == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outs("abort");
                exp_addr.delete();
                exp_tile.delete();
                @(posedge clk); @(posedge clk); #1;
                check_reset_outs("abort_hold");
                rst_n = 1'b1;
                tile_ready = 1'b0;
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout got=no done expected=done within 5000 cycles");
        end else if (bad)
            check("done_cycle_bad", done_cyc, 1);
        else begin
            check("first_valid_cycle", first_v, ELEMS + 2);
            check("done_after_last_hs", done_cyc, prev_hs + 1);
        end
        tile_ready = 1'b0;
        @(negedge clk);
        check("done_pulse", {done, busy, err}, '0);
        check("read_count", n_reads, exp_reads);
        check("tiles_left", exp_tile.size(), 0);
        check("reads_left", exp_addr.size(), 0);
    endtask

    initial begin
        tile_ready = 1'b0; dram_addr = '0; rows = '0; cols = '0; stride = '0;
        #12;
        check_reset_outs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // 2x40 at 0x100: padding in the second tile of each row.
        run_cmd(24'h000100, 2, 40, 0, 1'b0, 0);
        check("t1_ntiles", got_tiles.size(), 4);
        check("t1_tile0_b0", got_tiles[0].data[7:0], 8'h01);
        check("t1_tile0_b31", got_tiles[0].data[255:248], 8'h1E);
        check("t1_tile0_lc", got_tiles[0].lc, 1'b0);
        check("t1_tile1_b7", got_tiles[1].data[63:56], 8'h26);
        check("t1_tile1_pad", got_tiles[1].data[255:64], '0);
        check("t1_tile1_lc", got_tiles[1].lc, 1'b1);
        check("t1_tile3_last", got_tiles[3].l, 1'b1);
        check("t1_reads", n_reads, 80);

        // Explicit pitch of 100.
        run_cmd(24'h000000, 3, 32, 100, 1'b0, 0);
        check("t2_ntiles", got_tiles.size(), 3);
        check("t2_row1_base", rd_log[32], 24'd100);
        check("t2_row2_base", rd_log[64], 24'd200);

        // Random backpressure.
        run_cmd(24'h002345, 3, 50, 60, 1'b1, 0);
        check("t3_ntiles", got_tiles.size(), 6);
        check("t3_reads", n_reads, 150);

        // Address wrap.
        run_cmd(24'hFFFFF0, 1, 32, 0, 1'b0, 0);
        check("t4_pre_wrap", rd_log[15], 24'hFFFFFF);
        check("t4_wrap0", rd_log[16], 24'h000000);
        check("t4_wrap_end", rd_log[31], 24'h00000F);

        // Reset during the second tile, then a clean command.
        run_cmd(24'h000500, 4, 64, 0, 1'b0, 1);
        run_cmd(24'h000040, 1, 8, 0, 1'b0, 0);
        check("t6_b0", got_tiles[0].data[7:0], 8'h40);
        check("t6_pad", got_tiles[0].data[255:64], '0);
        check("t6_last", {got_tiles[0].lc, got_tiles[0].l}, 2'b11);

        // Zero rows: no reads, done next cycle.
        run_cmd(24'h000100, 0, 16, 0, 1'b0, 0);
        check("t7_reads", n_reads, 0);

        // Overlapping stride (error only with the dimension check).
        run_cmd(24'h000010, 2, 16, 8, 1'b0, 0);

        // Widest row: 32 tiles, last one with a single padding lane.
        run_cmd(24'h000000, 1, 1023, 0, 1'b0, 0);
        check("t9_ntiles", got_tiles.size(), 32);
        check("t9_last_pad", got_tiles[31].data[255:248], 8'h00);
        check("t9_last_b30", got_tiles[31].data[247:240], memf(24'd1022));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_m_strided.md
# load_m_strided

Parametrised successor to the matrix tile loader. It reads a `rows` × `cols` matrix of `DATA_WIDTH`-bit elements through an external synchronous read port. Rows may sit at an arbitrary pitch in memory. The block emits each row as zero-padded `TILE_WIDTH`-bit tiles over a valid/ready handshake with backpressure. It sits between the DRAM model and the systolic-array weight/activation buffers.

## Interface
- `TILE_WIDTH`, 256: tile width in bits; must be a multiple of `DATA_WIDTH`.
- `DATA_WIDTH`, 8: element width.
- `ADDR_WIDTH`, 24: element address width.
- `DIM_WIDTH`, 10: width of `rows`, `cols` and `stride`.
- `clk` in 1: clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle command strobe; sampled only in IDLE.
- `dram_addr` in ADDR_WIDTH: element address of row 0, column 0.
- `rows` in DIM_WIDTH: row count.
- `cols` in DIM_WIDTH: valid columns per row.
- `stride` in DIM_WIDTH: row pitch in elements; 0 means pitch = `cols`.
- `mem_re` out 1: read enable.
- `mem_addr` out ADDR_WIDTH: read address.
- `mem_rdata` in DATA_WIDTH: read data, valid exactly 1 cycle after `mem_re`.
- `tile_data` out TILE_WIDTH: element e occupies bits [e*DATA_WIDTH +: DATA_WIDTH].
- `tile_valid` out 1: tile available.
- `tile_ready` in 1: consumer accepts.
- `tile_last_col` out 1: tile is the last one of its row (qualified by `tile_valid`).
- `tile_last` out 1: tile is the last one of the command.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at command completion.
- `err` out 1: dimension-error pulse; see Configuration.

## Operation
- ELEMS = TILE_WIDTH/DATA_WIDTH.
- `tiles_per_row` = ceil(cols/ELEMS), computed at DIM_WIDTH+1 bits. `cols` = 1023 must not overflow.
- Command inputs are latched on `start` in IDLE. `start` while not IDLE is ignored.
- Pitch P = (stride == 0) ? cols : stride.
- Row r base = dram_addr + r*P. Element (r,c) address = base + c. All address arithmetic is modulo 2^ADDR_WIDTH, so it wraps silently.
- States:
  - IDLE → FETCH on `start`.
  - FETCH issues one slot per cycle for lanes 0..ELEMS-1 of the current tile.
    - Slot with column c < cols: `mem_re`=1, `mem_addr` = element address. The returned data is written to that lane on the next cycle.
    - Slot with c ≥ cols (padding): `mem_re`=0 and the lane is written with zero. No read is issued.
  - After lane ELEMS-1, FETCH → WAIT, which captures the final read.
  - WAIT → EMIT.
  - EMIT holds `tile_valid`=1 with `tile_data` stable until `tile_ready`.
  - On handshake, EMIT → FETCH for the next tile. After the last tile, EMIT → DONE.
  - Moving to a new row resets the column to 0 and advances the base by P.
  - DONE pulses `done`, then → IDLE.
- `tile_last_col` and `tile_last` are registered with the tile and are valid during EMIT.
- Memory accesses are in strict ascending column order within a row. No address is read twice.

## Timing
- Reset values: `tile_data`=0, `tile_valid`=0, `tile_last_col`=0, `tile_last`=0, `mem_re`=0, `mem_addr`=0, `busy`=0, `done`=0, `err`=0; state=IDLE.
- `start` at cycle 0 → first `mem_re` at cycle 1 → first `tile_valid` at cycle ELEMS+2.
- With `tile_ready` held high, tiles are spaced ELEMS+2 cycles apart.
- `done` rises the cycle after the final handshake. `busy` falls in that same cycle.
- `tile_ready` asserted outside EMIT has no effect.
- `tile_valid` never drops before its handshake.
- `rows` = 0 or `cols` = 0: no reads and no tiles. The block goes to DONE the cycle after `start`.
- Reset asserted mid-command aborts immediately: all outputs return to reset values, and no partial tile is ever presented.

## Configuration
- `LOAD_M_DIM_CHECK_EN` defined: `start` with `rows`==0 or `cols`==0, or with stride ≠ 0 and stride < cols, pulses `err` for one cycle. The block then pulses `done` without reading memory.
- `LOAD_M_DIM_CHECK_EN` undefined:
  - `err` is tied to 0.
  - Zero dimensions behave as described in Timing.
  - A stride below `cols` is honoured as given, so rows overlap.

## Structure
- Package `load_m_pkg` holds:
  - the state enum (IDLE, FETCH, WAIT, EMIT, DONE);
  - a `ceil_div` function;
  - the default width constants.
- One sub-module, `load_m_addr_gen`, computes the row base, column and tile counters and produces `mem_re`/`mem_addr`, plus the padding and last flags. The top level holds the tile register and the handshake.

## Test plan
- rows=2, cols=40, stride=0, addr 0x100, ready high → 4 tiles.
  - Tile 0: bytes 0x100–0x11F.
  - Tile 1: 0x120–0x127 then 24 zeros, with `tile_last_col`=1.
  - Tile 3 has `tile_last`=1.
  - Exactly 80 reads are issued.
- rows=3, cols=32, stride=100, addr 0x0 → row bases 0, 100, 200; 3 tiles; no padding.
- Random `tile_ready` stalls of 0–10 cycles → `tile_data` stays stable while stalled, no tile is lost or duplicated, and the read count is unchanged.
- addr 0xFFFFF0, cols=32, rows=1 → reads wrap to 0x000000–0x00000F.
- Reset during the second tile of rows=4, cols=64 → outputs return to reset values. A following command runs cleanly.
- rows=0, cols=16, with and without `LOAD_M_DIM_CHECK_EN` → no reads, `done` the next cycle, and `err`=1 only when the macro is defined.
